// File: rtl/cic_comp_fir.sv
// cic_comp_fir: symmetric CIC droop-compensation FIR with one time-multiplexed pre-add/MAC datapath.
// Define CIC_COMP_SAT_EN to clip the rounded result (and pulse sat); otherwise the result wraps.
module cic_comp_fir #(
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int NTAPS       = 15,
  parameter int ACC_WIDTH   = 40
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic signed [DATA_WIDTH-1:0]  x_in,
  output logic                          in_ready,
  input  logic                          coeff_we,
  input  logic        [4:0]             coeff_addr,
  input  logic signed [COEFF_WIDTH-1:0] coeff_data,
  output logic                          out_valid,
  output logic signed [DATA_WIDTH-1:0]  y_out,
  output logic                          overrun,
  output logic                          sat
);
  localparam int M  = (NTAPS + 1) / 2;
  localparam int KW = $clog2(M);
  localparam int XW = $clog2(NTAPS);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MAC   = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;
  localparam logic signed [ACC_WIDTH-1:0] RND = ACC_WIDTH'(1) <<< (COEFF_WIDTH - 2);
  localparam logic signed [COEFF_WIDTH-1:0] C_CTR = {1'b0, {(COEFF_WIDTH-1){1'b1}}};
  logic        [1:0]                  r_state;
  logic        [KW-1:0]               r_k;
  logic signed [DATA_WIDTH-1:0]       r_x [NTAPS];
  logic signed [COEFF_WIDTH-1:0]      r_c [M];
  logic signed [ACC_WIDTH-1:0]        r_acc;
  logic        [XW-1:0]               w_j;
  logic                               w_last;
  logic signed [DATA_WIDTH:0]         w_pre;
  logic signed [DATA_WIDTH+COEFF_WIDTH:0] w_prod;
  logic signed [DATA_WIDTH-1:0]       w_y;
  logic                               w_sat;
  assign in_ready = (r_state == S_IDLE);
  assign w_last   = (r_k == KW'(M - 1));
  assign w_j      = XW'(NTAPS - 1) - XW'(r_k);
  // Centre tap is not paired, so it enters the multiplier without the pre-add
  assign w_pre  = w_last ? (DATA_WIDTH+1)'(r_x[M-1])
                         : (DATA_WIDTH+1)'(r_x[r_k]) + (DATA_WIDTH+1)'(r_x[w_j]);
  assign w_prod = w_pre * r_c[r_k];
`ifdef CIC_COMP_SAT_EN
  logic signed [ACC_WIDTH-1:0] w_r;
  logic                        w_ovf;
  assign w_r   = (r_acc + RND) >>> (COEFF_WIDTH - 1);
  assign w_ovf = ~(&w_r[ACC_WIDTH-1:DATA_WIDTH-1] | ~|w_r[ACC_WIDTH-1:DATA_WIDTH-1]);
  assign w_y   = w_ovf ? (w_r[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                           : {1'b0, {(DATA_WIDTH-1){1'b1}}})
                       : w_r[DATA_WIDTH-1:0];
  assign w_sat = w_ovf;
`else
  assign w_y   = DATA_WIDTH'((r_acc + RND) >>> (COEFF_WIDTH - 1));
  assign w_sat = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_k       <= '0;
      r_acc     <= '0;
      out_valid <= 1'b0;
      y_out     <= '0;
      overrun   <= 1'b0;
      sat       <= 1'b0;
      for (int i = 0; i < NTAPS; i++) r_x[i] <= '0;
      for (int i = 0; i < M; i++) r_c[i] <= (i == M - 1) ? C_CTR : '0;
    end else begin
      out_valid <= 1'b0;
      sat       <= 1'b0;
      if (in_valid && r_state != S_IDLE) overrun <= 1'b1;
      if (coeff_we && r_state == S_IDLE && coeff_addr < 5'(M)) r_c[coeff_addr[KW-1:0]] <= coeff_data;
      case (r_state)
        S_IDLE: if (in_valid) begin
          for (int i = NTAPS - 1; i > 0; i--) r_x[i] <= r_x[i-1];
          r_x[0]  <= x_in;
          r_acc   <= '0;
          r_k     <= '0;
          r_state <= S_MAC;
        end
        S_MAC: begin
          r_acc   <= r_acc + ACC_WIDTH'(w_prod);
          r_k     <= r_k + 1'b1;
          r_state <= w_last ? S_ROUND : S_MAC;
        end
        S_ROUND: begin
          y_out     <= w_y;
          sat       <= w_sat;
          out_valid <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cic_comp_fir.sv
// tb_cic_comp_fir: directed + randomized check of cic_comp_fir against a direct-form convolution model.
module tb_cic_comp_fir;
  logic               clk, rst_n, in_valid, in_ready, coeff_we, out_valid, overrun, sat;
  logic signed [15:0] x_in, coeff_data, y_out;
  logic        [4:0]  coeff_addr;
  int                 tests, fails, bz_at;
  logic               bz_iv, bz_we;
  longint             cm [8];
  longint             hm [15];
  longint             yprev;

  cic_comp_fir dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x_in(x_in), .in_ready(in_ready),
    .coeff_we(coeff_we), .coeff_addr(coeff_addr), .coeff_data(coeff_data),
    .out_valid(out_valid), .y_out(y_out), .overrun(overrun), .sat(sat)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < 8; i++) cm[i] = 0;
    cm[7] = 32767;
    for (int i = 0; i < 15; i++) hm[i] = 0;
    yprev = 0;
  endtask

  task automatic model(output longint y, output logic s);
    longint acc, r;
    logic [63:0] t;
    acc = 0;
    for (int j = 0; j < 15; j++) acc += hm[j] * cm[j < 8 ? j : 14 - j];
    r = (acc + 16384) >>> 15;
`ifdef CIC_COMP_SAT_EN
    s = (r > 32767) || (r < -32768);
    y = r > 32767 ? 32767 : (r < -32768 ? -32768 : r);
`else
    s = 0;
    t = r;
    y = longint'($signed(t[15:0]));
`endif
  endtask

  task automatic wc(input logic [4:0] a, input logic signed [15:0] d);
    coeff_we = 1; coeff_addr = a; coeff_data = d;
    if (a < 8) cm[int'(a)] = longint'(d);
    @(negedge clk);
    coeff_we = 0;
  endtask

  task automatic send(input logic signed [15:0] x, input int gap, input logic wr = 0,
                      input logic [4:0] wa = 0, input logic signed [15:0] wd = 0);
    longint ey;
    logic es;
    in_valid = 1; x_in = x; coeff_we = wr; coeff_addr = wa; coeff_data = wd;
    if (wr && wa < 8) cm[int'(wa)] = longint'(wd);
    for (int i = 14; i > 0; i--) hm[i] = hm[i-1];
    hm[0] = longint'(x);
    model(ey, es);
    @(negedge clk);
    in_valid = 0; coeff_we = 0;
    for (int n = 1; n <= gap; n++) begin
      if (n == 1) chk("y_hold", y_out, yprev);
      chk("in_ready", in_ready, n >= 10);
      chk("out_valid", out_valid, n == 10);
      if (n == 10) begin
        chk("y_out", y_out, ey);
        chk("sat", sat, es);
        yprev = ey;
      end
      in_valid = (n == bz_at) && bz_iv;
      coeff_we = (n == bz_at) && bz_we;
      x_in = 16'sd12345; coeff_addr = 5'd7; coeff_data = 16'sd0;
      if (n < gap) @(negedge clk);
    end
  endtask

  initial begin
    tests = 0; fails = 0; bz_at = 0; bz_iv = 0; bz_we = 0;
    rst_n = 0; in_valid = 0; x_in = 0; coeff_we = 0; coeff_addr = 0; coeff_data = 0;
    mreset();
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y_out", y_out, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_sat", sat, 0);
    rst_n = 1;
    @(negedge clk);
    send(16'sd1000, 12);
    repeat (8) send(16'sd0, 12);
    for (int k = 0; k < 8; k++) wc(5'(k), 16'(10 * (k + 1)));
    wc(5'd9, 16'sd1234);
    send(16'sd32767, 10);
    repeat (14) send(16'sd0, 12);
    send(-16'sd2000, 11, 1'b1, 5'd7, 16'sd16384);
    for (int k = 0; k < 8; k++) wc(5'(k), 16'($urandom));
    repeat (20) send(16'($urandom), int'($urandom_range(10, 13)));
    chk("overrun_clear", overrun, 0);
    for (int k = 0; k < 7; k++) wc(5'(k), 16'sd0);
    wc(5'd7, 16'sd32767);
    bz_at = 4; bz_iv = 1;
    send(16'sd1000, 12);
    bz_iv = 0;
    chk("overrun_set", overrun, 1);
    bz_at = 3; bz_we = 1;
    send(16'sd0, 12);
    bz_we = 0;
    repeat (7) send(16'sd0, 12);
    chk("overrun_sticky", overrun, 1);
    for (int k = 0; k < 8; k++) wc(5'(k), 16'sh7FFF);
    repeat (15) send(16'sd32767, 12);
    in_valid = 1; x_in = 16'sd5000;
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
    rst_n = 0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_y_out", y_out, 0);
    chk("abort_overrun", overrun, 0);
    chk("abort_sat", sat, 0);
    mreset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      chk("abort_no_valid", out_valid, 0);
    end
    send(16'sd1000, 12);
    repeat (8) send(16'sd0, 12);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
